alu_src_b_mux: RTL and testbench
================================

Name: alu_src_b_mux

Overview:
- Selects the ALU B operand in the multicycle CPU datapath.
- Chooses among the B register (data0), a constant increment (4, for PC+4), the sign-extended immediate (data2) and the shifted immediate (data3), driven by control signal AluSrcB.
- Provides a combinational output `out` for same-cycle ALU use.
- Also provides a registered copy `out_q` for pipelined or timing-relaxed consumers.

Parameters:
- WIDTH, 32, datapath width of all data ports.
- INC_CONST, 4, constant driven when AluSrcB = 2'b01.

Ports:
- clk  input  1  rising-edge clock for the registered copy.
- reset_n  input  1  asynchronous active-low reset.
- data0  input  WIDTH  B register value.
- data2  input  WIDTH  sign-extended immediate.
- data3  input  WIDTH  immediate already shifted left 2 (branch offset).
- AluSrcB  input  2  operand select.
- en  input  1  load enable for the registered copy.
- out  output  WIDTH  combinational selected operand.
- out_q  output  WIDTH  registered selected operand.
- sel_q  output  2  AluSrcB value captured alongside out_q.

Behaviour:
- out is purely combinational, zero cycles of latency, with no dependence on clk or reset_n:
  - AluSrcB = 00 -> data0
  - AluSrcB = 01 -> INC_CONST, zero-extended to WIDTH
  - AluSrcB = 10 -> data2
  - AluSrcB = 11 -> data3
- All four select codes are legal. There is no X-propagation special case; out follows the inputs immediately when AluSrcB or any data input changes.
- Registered copy:
  - On posedge clk with en = 1: out_q <= the current value of out, and sel_q <= AluSrcB.
  - With en = 0: out_q and sel_q hold their values.
- Reset: reset_n low asynchronously forces out_q = 0 and sel_q = 2'b00, regardless of clk or en.
  - Release is synchronous to the next clk edge. The first capture happens on the first posedge where reset_n = 1 and en = 1.
  - Reset asserted mid-operation clears the registers immediately. out keeps tracking its inputs throughout reset.
- Simultaneous select and data change in the same cycle: out_q captures the value settled before the edge. No glitch requirements apply to out.
- Width rule: INC_CONST is truncated to WIDTH if it is wider. No arithmetic is performed inside the block.

Optional Feature:
- Macro ALU_SRCB_SHIFT_EN.
- Defined:
  - Select 11 drives data3 shifted left by 2, with zeros shifted in and the upper bits dropped.
  - data3 is then treated as the raw sign-extended immediate.
- Undefined (default): select 11 drives data3 unchanged.
- out_q follows whichever value out produces.

Decomposition:
- Shared package alu_src_b_pkg holds:
  - Select encodings as named constants: SRCB_REG = 2'b00, SRCB_INC = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11.
  - The default INC_CONST = 4.
- One natural sub-module, alu_src_b_reg: the enable/reset register for out_q and sel_q. The top level holds the combinational mux.

Test Plan:
- Combinational sweep with data0 = 0, data2 = 1, data3 = 2, stepping AluSrcB through 00/01/10/11 -> out = 0, 4, 1, 2.
- data0 = 32'hDEADBEEF, AluSrcB = 00, then changing data0 to 32'h12345678 without any clock edge -> out tracks both values immediately.
- Hold reset_n = 0 with clk running and AluSrcB = 01 -> out_q = 0, sel_q = 00, while out = 4. After reset_n goes high and one edge with en = 1 -> out_q = 4, sel_q = 01.
- en = 0 after capturing 4, then AluSrcB = 10 with data2 = 7 -> out = 7 and out_q stays 4. After en = 1 and one edge -> out_q = 7.
- Drop reset_n asynchronously between clock edges while out_q = 7 -> out_q = 0 at once, with no clock edge needed.
- With ALU_SRCB_SHIFT_EN defined, data3 = 3 and AluSrcB = 11 -> out = 12. With data3 = 32'h40000001 -> out = 32'h00000004 (upper bits dropped).

Source files
------------

// File: rtl/alu_src_b_pkg.sv
// Shared constants for the ALU B-operand select: select encodings and the
// default increment constant used for PC+4.
package alu_src_b_pkg;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_INC    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam int unsigned INC_CONST_DEFAULT = 4;

endpackage : alu_src_b_pkg

// File: rtl/alu_src_b_reg.sv
// Load-enable register holding the selected operand and its select code.
// Asynchronous active-low clear; holds when en_i is low.
module alu_src_b_reg
  import alu_src_b_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [1:0]       sel_i,
  output logic [WIDTH-1:0] q_o,
  output logic [1:0]       sel_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       sel_q, sel_d;

  // en_i is a plain load enable: no handshake, capture happens on every
  // rising edge where it is high, otherwise the stored pair is held.
  always_comb begin
    data_d = data_q;
    sel_d  = sel_q;
    if (en_i) begin
      data_d = d_i;
      sel_d  = sel_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      sel_q  <= SRCB_REG;
    end else begin
      data_q <= data_d;
      sel_q  <= sel_d;
    end
  end

  assign q_o   = data_q;
  assign sel_o = sel_q;

endmodule : alu_src_b_reg

// File: rtl/alu_src_b_mux.sv
// ALU B-operand select for the multicycle datapath, with a registered copy.
// Optional macro ALU_SRCB_SHIFT_EN: select 11 drives data3 shifted left by 2.
module alu_src_b_mux
  import alu_src_b_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned INC_CONST = INC_CONST_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  logic [1:0]       AluSrcB,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q
);

  // Wider constants are truncated, narrower ones zero-extended.
  localparam logic [WIDTH-1:0] INC_VAL = WIDTH'(INC_CONST);

  logic [WIDTH-1:0] data3_eff;
  logic [WIDTH-1:0] out_sel;

`ifdef ALU_SRCB_SHIFT_EN
  assign data3_eff = {data3[WIDTH-3:0], 2'b00};
`else
  assign data3_eff = data3;
`endif

  always_comb begin
    out_sel = data0;
    case (AluSrcB)
      SRCB_REG: out_sel = data0;
      SRCB_INC: out_sel = INC_VAL;
      SRCB_IMM: out_sel = data2;
      default:  out_sel = data3_eff;
    endcase
  end

  assign out = out_sel;

  alu_src_b_reg #(
    .WIDTH(WIDTH)
  ) u_reg (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (en),
    .d_i    (out_sel),
    .sel_i  (AluSrcB),
    .q_o    (out_q),
    .sel_o  (sel_q)
  );

endmodule : alu_src_b_mux

// File: tb/tb_alu_src_b_mux.sv
// Directed bench for alu_src_b_mux: combinational select, registered copy,
// enable hold and asynchronous reset.
module tb_alu_src_b_mux;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] data0 = '0;
  logic [W-1:0] data2 = '0;
  logic [W-1:0] data3 = '0;
  logic [1:0]   AluSrcB = 2'b00;
  logic         en = 1'b0;
  logic [W-1:0] out;
  logic [W-1:0] out_q;
  logic [1:0]   sel_q;

  int total = 0;
  int bad   = 0;

  alu_src_b_mux #(
    .WIDTH(W),
    .INC_CONST(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .data0  (data0),
    .data2  (data2),
    .data3  (data3),
    .AluSrcB(AluSrcB),
    .en     (en),
    .out    (out),
    .out_q  (out_q),
    .sel_q  (sel_q)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then park on the falling edge so drives and
  // samples stay away from the active edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  logic [W-1:0] sweep_exp [4];

  initial begin
    // reset state, clock running, en high to prove reset dominates
    en = 1'b1;
    repeat (2) tick();
    check("rst_out_q", out_q, 32'h0);
    check("rst_sel_q", {30'h0, sel_q}, 32'h0);

    // combinational sweep
    data0 = 32'd0; data2 = 32'd1; data3 = 32'd2;
    sweep_exp[0] = 32'd0;
    sweep_exp[1] = 32'd4;
    sweep_exp[2] = 32'd1;
`ifdef ALU_SRCB_SHIFT_EN
    sweep_exp[3] = 32'd8;
`else
    sweep_exp[3] = 32'd2;
`endif
    for (int i = 0; i < 4; i++) begin
      AluSrcB = 2'(i);
      #1;
      check($sformatf("sweep_sel%0d", i), out, sweep_exp[i]);
    end

    // out tracks data0 with no clock edge in between
    @(negedge clk);
    AluSrcB = 2'b00;
    data0 = 32'hDEADBEEF;
    #1 check("track_a", out, 32'hDEADBEEF);
    data0 = 32'h12345678;
    #1 check("track_b", out, 32'h12345678);

    // held in reset with select 01
    AluSrcB = 2'b01;
    en = 1'b1;
    repeat (3) tick();
    check("rsthold_out_q", out_q, 32'h0);
    check("rsthold_sel_q", {30'h0, sel_q}, 32'h0);
    check("rsthold_out", out, 32'd4);

    // release between edges, first capture on the next edge
    reset_n = 1'b1;
    #1 check("release_no_edge", out_q, 32'h0);
    tick();
    check("cap_inc_out_q", out_q, 32'd4);
    check("cap_inc_sel_q", {30'h0, sel_q}, 32'd1);

    // enable low holds
    en = 1'b0;
    AluSrcB = 2'b10;
    data2 = 32'd7;
    #1 check("hold_out", out, 32'd7);
    repeat (2) tick();
    check("hold_out_q", out_q, 32'd4);
    check("hold_sel_q", {30'h0, sel_q}, 32'd1);
    en = 1'b1;
    tick();
    check("cap_imm_out_q", out_q, 32'd7);
    check("cap_imm_sel_q", {30'h0, sel_q}, 32'd2);

    // asynchronous reset between edges
    #1 reset_n = 1'b0;
    #1;
    check("async_out_q", out_q, 32'h0);
    check("async_sel_q", {30'h0, sel_q}, 32'h0);
    check("async_out", out, 32'd7);
    tick();
    reset_n = 1'b1;

    // simultaneous select and data change, then capture
    AluSrcB = 2'b11;
    data3 = 32'd3;
    #1;
`ifdef ALU_SRCB_SHIFT_EN
    check("sh3_out", out, 32'd12);
`else
    check("sh3_out", out, 32'd3);
`endif
    tick();
`ifdef ALU_SRCB_SHIFT_EN
    check("sh3_out_q", out_q, 32'd12);
`else
    check("sh3_out_q", out_q, 32'd3);
`endif
    check("sh3_sel_q", {30'h0, sel_q}, 32'd3);

    data3 = 32'h40000001;
    #1;
`ifdef ALU_SRCB_SHIFT_EN
    check("shtop_out", out, 32'h00000004);
`else
    check("shtop_out", out, 32'h40000001);
`endif

    // select 00 capture of a wide value
    AluSrcB = 2'b00;
    data0 = 32'hA5A5_0F0F;
    tick();
    check("cap_reg_out_q", out_q, 32'hA5A5_0F0F);
    check("cap_reg_sel_q", {30'h0, sel_q}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_src_b_mux
